// File: rtl/tcb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tcb_pkg                                                       |
// | Purpose  : Shared TCB bus definitions: physical bus geometry, request    |
// |            and response structures, and an alignment helper.             |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package tcb_pkg;

   // Physical bus geometry: address width and data width in bits.
   typedef struct packed {
      int unsigned ADR;
      int unsigned DAT;
   } tcb_phy_t;

   localparam tcb_phy_t TCB_PHY_DEF = '{ADR: 32, DAT: 32};

   localparam int unsigned PHY_ADR = TCB_PHY_DEF.ADR;
   localparam int unsigned PHY_DAT = TCB_PHY_DEF.DAT;
   localparam int unsigned PHY_BEN = PHY_DAT / 8;
   // Number of address bits that select a byte lane inside one bus word.
   localparam int unsigned PHY_MAX = $clog2(PHY_BEN);

   typedef struct packed {
      logic err;
   } sts_t;

   typedef struct packed {
      logic               wen;
      logic [PHY_ADR-1:0] adr;
      logic [1:0]         siz;   // transfer size is 2**siz bytes
      logic [PHY_BEN-1:0] ben;
      logic [PHY_DAT-1:0] wdt;
   } req_t;

   typedef struct packed {
      logic [PHY_DAT-1:0] rdt;
      sts_t               sts;
   } rsp_t;

   // True when the low address bits are not a multiple of 2**siz bytes.
   // Only the three lowest bits matter since siz never exceeds 3.
   function automatic logic tcb_misaligned(input logic [2:0] adr_lo,
                                           input logic [1:0] siz);
      logic [2:0] msk;
      msk = ~(3'b111 << siz);
      return |(adr_lo & msk);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tcb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tcb_if                                                        |
// | Purpose  : TCB point-to-point bus bundle between a manager and a         |
// |            subordinate.                                                  |
// | Signals  : vld - request valid (manager)                                 |
// |            req - request payload (manager)                               |
// |            rdy - subordinate ready (subordinate)                         |
// |            rsp - response payload (subordinate)                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface tcb_if;
   import tcb_pkg::*;

   logic vld;
   req_t req;
   logic rdy;
   rsp_t rsp;

   modport man (output vld, output req, input  rdy, input  rsp);
   modport sub (input  vld, input  req, output rdy, output rsp);

endinterface
`default_nettype wire

// File: rtl/tcb_lib_delay.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tcb_lib_delay                                                 |
// | Purpose  : Response delay line. Stage 1 captures i_din only when i_ena   |
// |            is high; later stages shift every cycle. DLY=0 is a wire.     |
// | Ports    : clk    - clock                                                |
// |            rst    - synchronous active-high reset, clears all stages     |
// |            i_ena  - load enable for the first stage (a transfer)         |
// |            i_din  - response to delay                                    |
// |            o_dout - delayed response (last stage)                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tcb_lib_delay #(
   parameter int unsigned DLY   = 1,
   parameter type         rsp_t = logic
)(
   input  logic clk,
   input  logic rst,
   input  logic i_ena,
   input  rsp_t i_din,
   output rsp_t o_dout
);

   generate
      if (DLY == 0) begin : g_bypass
         // Purely combinational path; clock, reset and enable have no role.
         logic w_unused;
         assign w_unused = &{1'b0, clk, rst, i_ena};
         assign o_dout   = i_din;
      end else begin : g_pipe
         rsp_t r_stg [DLY];

         // Stage 1 holds its value between transfers so the output keeps
         // the last response instead of drifting to idle garbage.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DLY; i++) begin
                  r_stg[i] <= '0;
               end
            end else begin
               if (i_ena) begin
                  r_stg[0] <= i_din;
               end
               for (int i = 1; i < DLY; i++) begin
                  r_stg[i] <= r_stg[i-1];
               end
            end
         end

         assign o_dout = r_stg[DLY-1];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/tcb_lib_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tcb_lib_memory                                                |
// | Purpose  : Byte-lane-writable memory behind a TCB subordinate port, with |
// |            address/alignment error reporting, a configurable response    |
// |            delay and optional forced stall cycles after each transfer.   |
// | Ports    : clk - clock                                                   |
// |            rst - synchronous active-high reset (memory is not cleared)   |
// |            tcb - TCB subordinate port; drives rdy and rsp                |
// | Params   : MEM_SIZ - memory size in bytes (power of two)                 |
// |            DLY     - response delay in cycles                            |
// |            STL     - not-ready cycles forced after each transfer         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tcb_lib_memory
   import tcb_pkg::*;
#(
   parameter int unsigned MEM_SIZ = 4096,
   parameter int unsigned DLY     = 1,
   parameter int unsigned STL     = 0
)(
   input  logic clk,
   input  logic rst,
   tcb_if.sub   tcb
);

   localparam int unsigned c_adr_w = $clog2(MEM_SIZ);
   localparam int unsigned c_words = MEM_SIZ / PHY_BEN;
   localparam int unsigned c_idx_w = c_adr_w - PHY_MAX;
   localparam int unsigned c_stl_w = (STL > 0) ? $clog2(STL + 1) : 1;

   logic [c_stl_w-1:0] r_stl_cnt;
   logic               w_rdy;
   logic               w_trn;
   logic               w_oor;
   logic               w_mis;
   logic               w_err;
   logic               w_wr;
   logic [c_idx_w-1:0] w_idx;
   logic [PHY_DAT-1:0] r_mem [c_words];
   rsp_t               w_rsp;
   rsp_t               w_rsp_dly;

   // ------------------------------------------------------------------
   // Handshake. Ready depends only on reset and the stall counter, never
   // on vld, so a manager may wait for rdy before raising vld.
   // ------------------------------------------------------------------
   assign w_rdy = ~rst & (r_stl_cnt == '0);
   assign w_trn = tcb.vld & w_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stl_cnt <= '0;
      end else if (w_trn) begin
         r_stl_cnt <= c_stl_w'(STL);
      end else if (r_stl_cnt != '0) begin
         r_stl_cnt <= r_stl_cnt - c_stl_w'(1);
      end
   end

   // ------------------------------------------------------------------
   // Address decode and error detection. Out-of-range addresses would
   // otherwise alias onto a valid word through the truncated index.
   // ------------------------------------------------------------------
   assign w_oor = (tcb.req.adr >= PHY_ADR'(MEM_SIZ));
   assign w_mis = tcb_misaligned(tcb.req.adr[2:0], tcb.req.siz);
   assign w_err = w_oor | w_mis;
   assign w_idx = tcb.req.adr[c_adr_w-1:PHY_MAX];

   // ------------------------------------------------------------------
   // Memory array: one word per entry, per-lane write enables. No reset
   // so the array maps onto block RAM with byte enables.
   // ------------------------------------------------------------------
   assign w_wr = w_trn & tcb.req.wen & ~w_err;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         for (int i = 0; i < PHY_BEN; i++) begin
            if (tcb.req.ben[i]) begin
               r_mem[w_idx][8*i +: 8] <= tcb.req.wdt[8*i +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Response formation. Reads return only enabled lanes; writes and
   // errored transfers return zero data.
   // ------------------------------------------------------------------
   always_comb begin
      w_rsp = '0;
      if (!w_err && !tcb.req.wen) begin
         for (int i = 0; i < PHY_BEN; i++) begin
            if (tcb.req.ben[i]) begin
               w_rsp.rdt[8*i +: 8] = r_mem[w_idx][8*i +: 8];
            end
         end
      end
      w_rsp.sts.err = w_err;
   end

   tcb_lib_delay #(
      .DLY   (DLY),
      .rsp_t (rsp_t)
   ) u_delay (
      .clk    (clk),
      .rst    (rst),
      .i_ena  (w_trn),
      .i_din  (w_rsp),
      .o_dout (w_rsp_dly)
   );

   assign tcb.rdy = w_rdy;
   assign tcb.rsp = w_rsp_dly;

endmodule
`default_nettype wire

// File: tb/tb_tcb_lib_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tcb_lib_memory                                             |
// | Purpose  : Self-checking bench for tcb_lib_memory. Five instances cover  |
// |            DLY=1, DLY=3, DLY=0, STL=2 and DLY=2. Expected responses are  |
// |            queued at transfer time with their due cycle and compared     |
// |            when that cycle arrives.                                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_tcb_lib_memory;
   import tcb_pkg::*;

   localparam int c_ndut = 5;

   typedef struct {
      logic        wen;
      logic [31:0] adr;
      logic [1:0]  siz;
      logic [3:0]  ben;
      logic [31:0] wdt;
      logic [31:0] rdt;
      logic        err;
      string       tag;
   } op_t;

   typedef struct {
      int          due;
      logic [31:0] rdt;
      logic        err;
      string       tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t sb [$];

   logic vld   [c_ndut];
   req_t req   [c_ndut];
   logic rdy_w [c_ndut];
   rsp_t rsp_w [c_ndut];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tcb_if u_if0 ();
   tcb_if u_if1 ();
   tcb_if u_if2 ();
   tcb_if u_if3 ();
   tcb_if u_if4 ();

   assign u_if0.vld = vld[0]; assign u_if0.req = req[0];
   assign u_if1.vld = vld[1]; assign u_if1.req = req[1];
   assign u_if2.vld = vld[2]; assign u_if2.req = req[2];
   assign u_if3.vld = vld[3]; assign u_if3.req = req[3];
   assign u_if4.vld = vld[4]; assign u_if4.req = req[4];
   assign rdy_w[0] = u_if0.rdy; assign rsp_w[0] = u_if0.rsp;
   assign rdy_w[1] = u_if1.rdy; assign rsp_w[1] = u_if1.rsp;
   assign rdy_w[2] = u_if2.rdy; assign rsp_w[2] = u_if2.rsp;
   assign rdy_w[3] = u_if3.rdy; assign rsp_w[3] = u_if3.rsp;
   assign rdy_w[4] = u_if4.rdy; assign rsp_w[4] = u_if4.rsp;

   tcb_lib_memory #(.MEM_SIZ(4096), .DLY(1), .STL(0)) u_dut0 (.clk(clk), .rst(rst), .tcb(u_if0));
   tcb_lib_memory #(.MEM_SIZ(4096), .DLY(3), .STL(0)) u_dut1 (.clk(clk), .rst(rst), .tcb(u_if1));
   tcb_lib_memory #(.MEM_SIZ(4096), .DLY(0), .STL(0)) u_dut2 (.clk(clk), .rst(rst), .tcb(u_if2));
   tcb_lib_memory #(.MEM_SIZ(4096), .DLY(1), .STL(2)) u_dut3 (.clk(clk), .rst(rst), .tcb(u_if3));
   tcb_lib_memory #(.MEM_SIZ(4096), .DLY(2), .STL(0)) u_dut4 (.clk(clk), .rst(rst), .tcb(u_if4));

   function automatic int dly_of(input int u);
      case (u)
         1:       return 3;
         2:       return 0;
         4:       return 2;
         default: return 1;
      endcase
   endfunction

   function automatic op_t mkop(input logic wen, input logic [31:0] adr, input logic [1:0] siz,
                                input logic [3:0] ben, input logic [31:0] wdt,
                                input logic [31:0] rdt, input logic err, input string tag);
      op_t o;
      o.wen = wen; o.adr = adr; o.siz = siz; o.ben = ben; o.wdt = wdt;
      o.rdt = rdt; o.err = err; o.tag = tag;
      return o;
   endfunction

   function automatic req_t to_req(input op_t o);
      req_t r;
      r.wen = o.wen; r.adr = o.adr; r.siz = o.siz; r.ben = o.ben; r.wdt = o.wdt;
      return r;
   endfunction

   // Drive one cycle of stimulus on the falling edge and report whether the
   // next rising edge will be a transfer.
   task automatic drive(input int u, input logic v, input req_t r, output logic t);
      @(negedge clk);
      vld[u] = v;
      req[u] = r;
      #1;
      t = v & rdy_w[u];
   endtask

   task automatic push_exp(input int u, input op_t o);
      exp_t e;
      e.due = cyc + dly_of(u);
      e.rdt = o.rdt;
      e.err = o.err;
      e.tag = o.tag;
      sb.push_back(e);
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      for (int u = 0; u < c_ndut; u++) begin
         vld[u] = 1'b0;
         req[u] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      for (int u = 0; u < c_ndut; u++) begin
         total++;
         if (rdy_w[u] !== 1'b0) begin
            bad++;
            $display("FAIL reset_rdy dut%0d: got %b want 0", u, rdy_w[u]);
         end
         total++;
         if (rsp_w[u] !== '0) begin
            bad++;
            $display("FAIL reset_rsp dut%0d: got %h want 0", u, rsp_w[u]);
         end
      end
      rst = 1'b0;
      #1;
      for (int u = 0; u < c_ndut; u++) begin
         total++;
         if (rdy_w[u] !== 1'b1) begin
            bad++;
            $display("FAIL rdy_after_reset dut%0d: got %b want 1", u, rdy_w[u]);
         end
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_write_read();
      int   u = 0;
      int   k = 0;
      logic t;
      exp_t e;
      op_t  ops [$];
      ops.push_back(mkop(1, 32'h10, 2, 4'hF, 32'hDEADBEEF, 32'h0,        0, "wr_full"));
      ops.push_back(mkop(0, 32'h10, 2, 4'hF, 32'h0,        32'hDEADBEEF, 0, "rd_full"));
      ops.push_back(mkop(1, 32'h10, 2, 4'h2, 32'h0000AA00, 32'h0,        0, "wr_lane1"));
      ops.push_back(mkop(0, 32'h10, 2, 4'hF, 32'h0,        32'hDEADAAEF, 0, "rd_after_partial"));
      ops.push_back(mkop(0, 32'h10, 2, 4'h3, 32'h0,        32'h0000AAEF, 0, "rd_ben3"));
      ops.push_back(mkop(0, 32'h1000, 2, 4'hF, 32'h0,      32'h0,        1, "rd_oor"));
      ops.push_back(mkop(0, 32'hFFFFFFFC, 2, 4'hF, 32'h0,  32'h0,        1, "rd_oor_top"));
      ops.push_back(mkop(1, 32'h12, 2, 4'hF, 32'h12345678, 32'h0,        1, "wr_misaligned"));
      ops.push_back(mkop(0, 32'h10, 2, 4'hF, 32'h0,        32'hDEADAAEF, 0, "rd_after_bad_wr"));
      ops.push_back(mkop(1, 32'h12, 1, 4'hC, 32'h55660000, 32'h0,        0, "wr_half_hi"));
      ops.push_back(mkop(0, 32'h10, 2, 4'hF, 32'h0,        32'h5566AAEF, 0, "rd_after_half"));
      ops.push_back(mkop(0, 32'h11, 1, 4'h3, 32'h0,        32'h0,        1, "rd_half_misaligned"));
      ops.push_back(mkop(1, 32'h1004, 2, 4'hF, 32'hFFFFFFFF, 32'h0,      1, "wr_oor"));
      ops.push_back(mkop(0, 32'h4, 0, 4'h0, 32'h0,         32'h0,        0, "rd_no_lanes"));
      for (int c = 0; c < ops.size() + 8; c++) begin
         if (k < ops.size()) drive(u, 1'b1, to_req(ops[k]), t);
         else                drive(u, 1'b0, '0, t);
         if (t) begin
            push_exp(u, ops[k]);
            k++;
         end
         while (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            total++;
            if (rsp_w[u].rdt !== e.rdt || rsp_w[u].sts.err !== e.err) begin
               bad++;
               $display("FAIL %s: got rdt=%h err=%b want rdt=%h err=%b",
                        e.tag, rsp_w[u].rdt, rsp_w[u].sts.err, e.rdt, e.err);
            end
         end
      end
      total++;
      if (k != ops.size() || sb.size() != 0) begin
         bad++;
         $display("FAIL write_read_complete: got issued=%0d pending=%0d want issued=%0d pending=0",
                  k, sb.size(), ops.size());
         sb.delete();
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_stall();
      int         u = 3;
      int         k = 0;
      logic       t;
      exp_t       e;
      op_t        ops [$];
      logic [0:6] pat = 7'b1001001;
      ops.push_back(mkop(1, 32'h20, 2, 4'hF, 32'hA1A1A1A1, 32'h0,        0, "stl_wr0"));
      ops.push_back(mkop(1, 32'h24, 2, 4'hF, 32'hB2B2B2B2, 32'h0,        0, "stl_wr1"));
      ops.push_back(mkop(0, 32'h20, 2, 4'hF, 32'h0,        32'hA1A1A1A1, 0, "stl_rd"));
      for (int c = 0; c < 12; c++) begin
         if (k < ops.size()) drive(u, 1'b1, to_req(ops[k]), t);
         else                drive(u, 1'b0, '0, t);
         if (c < 7) begin
            total++;
            if (rdy_w[u] !== pat[c]) begin
               bad++;
               $display("FAIL stall_rdy cycle%0d: got %b want %b", c, rdy_w[u], pat[c]);
            end
         end
         if (t) begin
            push_exp(u, ops[k]);
            k++;
         end
         while (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            total++;
            if (rsp_w[u].rdt !== e.rdt || rsp_w[u].sts.err !== e.err) begin
               bad++;
               $display("FAIL %s: got rdt=%h err=%b want rdt=%h err=%b",
                        e.tag, rsp_w[u].rdt, rsp_w[u].sts.err, e.rdt, e.err);
            end
         end
      end
      total++;
      if (k != 3 || sb.size() != 0) begin
         bad++;
         $display("FAIL stall_transfers: got %0d pending=%0d want 3 pending=0", k, sb.size());
         sb.delete();
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_delay();
      int   u;
      int   k;
      logic t;
      exp_t e;
      op_t  ops [$];
      for (int pass = 0; pass < 2; pass++) begin
         ops.delete();
         k = 0;
         if (pass == 0) begin
            u = 1;
            ops.push_back(mkop(1, 32'h0, 2, 4'hF, 32'h11111111, 32'h0,        0, "d3_wr0"));
            ops.push_back(mkop(1, 32'h4, 2, 4'hF, 32'h22222222, 32'h0,        0, "d3_wr4"));
            ops.push_back(mkop(1, 32'h8, 2, 4'hF, 32'h33333333, 32'h0,        0, "d3_wr8"));
            ops.push_back(mkop(0, 32'h0, 2, 4'hF, 32'h0,        32'h11111111, 0, "d3_rd0"));
            ops.push_back(mkop(0, 32'h4, 2, 4'hF, 32'h0,        32'h22222222, 0, "d3_rd4"));
            ops.push_back(mkop(0, 32'h8, 2, 4'hF, 32'h0,        32'h33333333, 0, "d3_rd8"));
         end else begin
            u = 2;
            ops.push_back(mkop(1, 32'h0, 2, 4'hF, 32'hCAFEF00D, 32'h0,        0, "d0_wr0"));
            ops.push_back(mkop(0, 32'h0, 2, 4'hF, 32'h0,        32'hCAFEF00D, 0, "d0_rd0"));
            ops.push_back(mkop(0, 32'h0, 2, 4'h1, 32'h0,        32'h0000000D, 0, "d0_rd_lane0"));
            ops.push_back(mkop(0, 32'h1000, 2, 4'hF, 32'h0,     32'h0,        1, "d0_rd_oor"));
         end
         for (int c = 0; c < ops.size() + 8; c++) begin
            if (k < ops.size()) drive(u, 1'b1, to_req(ops[k]), t);
            else                drive(u, 1'b0, '0, t);
            if (t) begin
               push_exp(u, ops[k]);
               k++;
            end
            while (sb.size() != 0 && sb[0].due == cyc) begin
               e = sb.pop_front();
               total++;
               if (rsp_w[u].rdt !== e.rdt || rsp_w[u].sts.err !== e.err) begin
                  bad++;
                  $display("FAIL %s: got rdt=%h err=%b want rdt=%h err=%b",
                           e.tag, rsp_w[u].rdt, rsp_w[u].sts.err, e.rdt, e.err);
               end
            end
         end
         total++;
         if (k != ops.size() || sb.size() != 0) begin
            bad++;
            $display("FAIL delay_complete dut%0d: got issued=%0d pending=%0d want issued=%0d pending=0",
                     u, k, sb.size(), ops.size());
            sb.delete();
         end
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset_midflight();
      int   u = 4;
      logic t;
      exp_t e;
      op_t  wr;
      op_t  rd;
      wr = mkop(1, 32'h40, 2, 4'hF, 32'h77777777, 32'h0,        0, "mf_wr");
      rd = mkop(0, 32'h40, 2, 4'hF, 32'h0,        32'h77777777, 0, "mf_rd_after_rst");
      drive(u, 1'b1, to_req(wr), t);
      if (t) push_exp(u, wr);
      for (int c = 0; c < 4; c++) begin
         drive(u, 1'b0, '0, t);
         while (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            total++;
            if (rsp_w[u].rdt !== e.rdt || rsp_w[u].sts.err !== e.err) begin
               bad++;
               $display("FAIL %s: got rdt=%h err=%b want rdt=%h err=%b",
                        e.tag, rsp_w[u].rdt, rsp_w[u].sts.err, e.rdt, e.err);
            end
         end
      end
      // Read transfer whose response must be discarded by the reset.
      drive(u, 1'b1, to_req(rd), t);
      total++;
      if (t !== 1'b1) begin
         bad++;
         $display("FAIL mf_read_accepted: got %b want 1", t);
      end
      @(negedge clk);
      rst    = 1'b1;
      vld[u] = 1'b0;
      #1;
      total++;
      if (rdy_w[u] !== 1'b0) begin
         bad++;
         $display("FAIL mf_rdy_in_rst: got %b want 0", rdy_w[u]);
      end
      @(negedge clk);
      #1;
      total++;
      if (rsp_w[u] !== '0) begin
         bad++;
         $display("FAIL mf_rsp_in_rst: got %h want 0", rsp_w[u]);
      end
      total++;
      if (rdy_w[u] !== 1'b0) begin
         bad++;
         $display("FAIL mf_rdy_in_rst2: got %b want 0", rdy_w[u]);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (rdy_w[u] !== 1'b1) begin
         bad++;
         $display("FAIL mf_rdy_after_rst: got %b want 1", rdy_w[u]);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         total++;
         if (rsp_w[u] !== '0) begin
            bad++;
            $display("FAIL mf_stale_rsp cycle%0d: got %h want 0", c, rsp_w[u]);
         end
      end
      // Memory contents survive reset.
      drive(u, 1'b1, to_req(rd), t);
      if (t) push_exp(u, rd);
      for (int c = 0; c < 5; c++) begin
         drive(u, 1'b0, '0, t);
         while (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            total++;
            if (rsp_w[u].rdt !== e.rdt || rsp_w[u].sts.err !== e.err) begin
               bad++;
               $display("FAIL %s: got rdt=%h err=%b want rdt=%h err=%b",
                        e.tag, rsp_w[u].rdt, rsp_w[u].sts.err, e.rdt, e.err);
            end
         end
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL mf_complete: got pending=%0d want 0", sb.size());
         sb.delete();
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_back_to_back();
      int          u = 0;
      int          k = 0;
      logic        t;
      exp_t        e;
      op_t         ops [$];
      logic [31:0] mdl [16];
      logic [31:0] adr;
      logic [31:0] wdt;
      logic [31:0] exp_rdt;
      logic [3:0]  ben;
      logic [1:0]  siz;
      logic        wen;
      logic        err;
      int          w;
      int          kind;
      for (int i = 0; i < 16; i++) begin
         mdl[i] = $urandom;
         ops.push_back(mkop(1, 32'h100 + 32'(4*i), 2, 4'hF, mdl[i], 32'h0, 0,
                            $sformatf("b2b_init%0d", i)));
      end
      for (int n = 0; n < 60; n++) begin
         w    = $urandom_range(0, 15);
         kind = $urandom_range(0, 9);
         wen  = 1'($urandom_range(0, 1));
         ben  = 4'($urandom);
         wdt  = $urandom;
         siz  = 2'd2;
         adr  = 32'h100 + 32'(4*w);
         if (kind == 0) begin
            adr = 32'h1000 + 32'(4*w);
         end else if (kind == 1) begin
            siz = 2'($urandom_range(1, 2));
            adr = adr + ((siz == 2'd1) ? 32'd1 : 32'd2);
         end else if (kind == 2) begin
            siz = 2'd1;
            adr = adr + 32'd2;
         end
         err = (adr >= 32'd4096) || (siz == 2'd1 && adr[0]) || (siz == 2'd2 && adr[1:0] != 2'd0);
         exp_rdt = 32'h0;
         if (!err) begin
            for (int i = 0; i < 4; i++) begin
               if (ben[i]) begin
                  if (wen) mdl[w][8*i +: 8] = wdt[8*i +: 8];
                  else     exp_rdt[8*i +: 8] = mdl[w][8*i +: 8];
               end
            end
         end
         ops.push_back(mkop(wen, adr, siz, ben, wdt, exp_rdt, err,
                            $sformatf("b2b%0d_%s_a%h_s%0d_b%h", n, wen ? "wr" : "rd", adr, siz, ben)));
      end
      for (int c = 0; c < ops.size() + 8; c++) begin
         if (k < ops.size()) drive(u, 1'b1, to_req(ops[k]), t);
         else                drive(u, 1'b0, '0, t);
         if (t) begin
            push_exp(u, ops[k]);
            k++;
         end
         while (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            total++;
            if (rsp_w[u].rdt !== e.rdt || rsp_w[u].sts.err !== e.err) begin
               bad++;
               $display("FAIL %s: got rdt=%h err=%b want rdt=%h err=%b",
                        e.tag, rsp_w[u].rdt, rsp_w[u].sts.err, e.rdt, e.err);
            end
         end
      end
      total++;
      if (k != ops.size() || sb.size() != 0) begin
         bad++;
         $display("FAIL b2b_complete: got issued=%0d pending=%0d want issued=%0d pending=0",
                  k, sb.size(), ops.size());
         sb.delete();
      end
   endtask

   // ---------------------------------------------------------------------
   initial begin
      rst = 1'b1;
      for (int u = 0; u < c_ndut; u++) begin
         vld[u] = 1'b0;
         req[u] = '0;
      end
      test_reset();
      test_write_read();
      test_stall();
      test_delay();
      test_reset_midflight();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
